// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the shared multi-cycle multiply/divide unit.
// Optional watchdog abort in WAIT is enabled by defining MULTDIV_WATCHDOG_EN.
module multdiv_sequencer #(
  parameter int LATENCY_MAX = 40,
  parameter int CNT_W       = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic             op_is_div,
  input  logic [4:0]       op_tag,
  input  logic [31:0]      operand_a,
  input  logic [31:0]      operand_b,
  input  logic             flush,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  output logic [31:0]      md_a,
  output logic [31:0]      md_b,
  input  logic [31:0]      md_result,
  input  logic             md_exception,
  input  logic             md_ready,
  output logic             pipeline_stall,
  output logic             result_valid,
  output logic [31:0]      result,
  output logic [4:0]       result_tag,
  output logic [2:0]       exc_code,
  output logic [CNT_W-1:0] busy_cycles,
  output logic             timeout_flag
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [4:0]  tag_reg;
  logic        is_div_reg;
  logic        accept;
  logic        capture;
  logic        wd_expire;

  // The busy counter must be able to represent the watchdog limit.
  if ((2 ** CNT_W) <= LATENCY_MAX) begin : g_bad_cnt_w
    $error("CNT_W too narrow for LATENCY_MAX");
  end

  assign accept  = (state == IDLE) && op_valid && !flush;
  assign capture = (state == WAIT) && md_ready && !flush;
  assign md_a    = a_reg;
  assign md_b    = b_reg;

`ifdef MULTDIV_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(LATENCY_MAX - 1);

  // Expires on the LATENCY_MAX-th WAIT cycle; a late md_ready still wins.
  assign wd_expire = (state == WAIT) && !md_ready && !flush && (busy_cycles == WD_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_flag <= 1'b0;
    end else if (wd_expire) begin
      timeout_flag <= 1'b1;
    end
  end
`else
  assign wd_expire    = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    pipeline_stall = 1'b0;
    md_ctrl_mult   = 1'b0;
    md_ctrl_div    = 1'b0;
    result_valid   = 1'b0;
    case (state)
      IDLE: begin
        pipeline_stall = op_valid;
        if (accept) state_next = START;
      end
      START: begin
        pipeline_stall = 1'b1;
        md_ctrl_mult   = !is_div_reg;
        md_ctrl_div    = is_div_reg;
        state_next     = flush ? IDLE : WAIT;
      end
      WAIT: begin
        pipeline_stall = 1'b1;
        if (flush) begin
          state_next = IDLE;
        end else if (md_ready || wd_expire) begin
          state_next = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      tag_reg     <= '0;
      is_div_reg  <= 1'b0;
      result      <= '0;
      result_tag  <= '0;
      exc_code    <= '0;
      busy_cycles <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_reg      <= operand_a;
        b_reg      <= operand_b;
        tag_reg    <= op_tag;
        is_div_reg <= op_is_div;
      end
      if (state == START) begin
        busy_cycles <= '0;
      end else if ((state == WAIT) && (busy_cycles != '1)) begin
        busy_cycles <= busy_cycles + 1'b1;
      end
      if (capture) begin
        result     <= md_result;
        result_tag <= tag_reg;
        exc_code   <= md_exception ? (is_div_reg ? 3'd5 : 3'd4) : 3'd0;
      end else if (wd_expire) begin
        result     <= '0;
        result_tag <= tag_reg;
        exc_code   <= is_div_reg ? 3'd5 : 3'd4;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized self-checking bench for multdiv_sequencer; the bench also plays the multiply/divide unit.
// Covers the MULTDIV_WATCHDOG_EN build when that macro is defined for the bench as well.
module tb_multdiv_sequencer;

  localparam int LAT_MAX = 40;
  localparam int CW      = 6;
  localparam int SAT     = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_is_div = 1'b0;
  logic [4:0]    op_tag = '0;
  logic [31:0]   operand_a = '0;
  logic [31:0]   operand_b = '0;
  logic          flush = 1'b0;
  logic          md_ctrl_mult;
  logic          md_ctrl_div;
  logic [31:0]   md_a;
  logic [31:0]   md_b;
  logic [31:0]   md_result = '0;
  logic          md_exception = 1'b0;
  logic          md_ready = 1'b0;
  logic          pipeline_stall;
  logic          result_valid;
  logic [31:0]   result;
  logic [4:0]    result_tag;
  logic [2:0]    exc_code;
  logic [CW-1:0] busy_cycles;
  logic          timeout_flag;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural view of the result registers as the bench expects them.
  logic [31:0] exp_result = '0;
  logic [4:0]  exp_tag    = '0;
  logic [2:0]  exp_exc    = '0;
  logic        exp_tflag  = 1'b0;

  multdiv_sequencer #(.LATENCY_MAX(LAT_MAX), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_is_div(op_is_div),
    .op_tag(op_tag), .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .md_a(md_a), .md_b(md_b),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .pipeline_stall(pipeline_stall), .result_valid(result_valid), .result(result),
    .result_tag(result_tag), .exc_code(exc_code), .busy_cycles(busy_cycles),
    .timeout_flag(timeout_flag)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] unit_value(input logic [31:0] a, input logic [31:0] b, input logic is_div);
    if (is_div) return (b == 0) ? 32'hFFFF_FFFF : a / b;
    return a * b;
  endfunction

  // lat = WAIT cycle on which md_ready rises; lat = 0 means the unit never answers.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic is_div,
                       input logic [4:0] tag, input int lat, input logic exc, input bit kill);
    int          ctrl_seen = 0;
    int          stall_low = 0;
    int          rv_early  = 0;
    int          wcycles   = (lat == 0) ? LAT_MAX : lat;
    logic [31:0] r         = unit_value(a, b, is_div);
    logic [2:0]  op_exc    = is_div ? 3'd5 : 3'd4;

    op_valid = 1'b1; op_is_div = is_div; op_tag = tag; operand_a = a; operand_b = b;
    @(negedge clock);
    check_eq("idle_stall", pipeline_stall, 1);
    check_eq("idle_no_start", {md_ctrl_mult, md_ctrl_div}, 0);
    check_eq("idle_no_rv", result_valid, 0);
    step();
    operand_a = $urandom; operand_b = $urandom; op_tag = 5'($urandom);
    @(negedge clock);
    check_eq("start_pulse", {md_ctrl_mult, md_ctrl_div}, is_div ? 2'b01 : 2'b10);
    check_eq("start_md_a", md_a, a);
    check_eq("start_md_b", md_b, b);
    check_eq("start_stall", pipeline_stall, 1);
    step();
    for (int i = 1; i <= wcycles; i++) begin
      md_ready     = (lat != 0) && (i == lat);
      md_result    = md_ready ? r : $urandom;
      md_exception = md_ready ? exc : 1'($urandom);
      flush        = kill && md_ready;
      @(negedge clock);
      if (md_ctrl_mult || md_ctrl_div) ctrl_seen++;
      if (!pipeline_stall) stall_low++;
      if (result_valid) rv_early++;
      step();
    end
    md_ready = 1'b0; md_exception = 1'b0; flush = 1'b0; md_result = $urandom;
    check_eq("wait_extra_pulses", ctrl_seen, 0);
    check_eq("wait_stall_drops", stall_low, 0);
    check_eq("wait_early_rv", rv_early, 0);
    if (kill) begin
      op_valid = 1'b0;
      @(negedge clock);
      check_eq("flush_no_rv", result_valid, 0);
      check_eq("flush_no_restart", {md_ctrl_mult, md_ctrl_div}, 0);
      check_eq("flush_stall", pipeline_stall, 0);
      check_eq("flush_result_kept", result, exp_result);
      check_eq("flush_tag_kept", result_tag, exp_tag);
      check_eq("flush_exc_kept", exc_code, exp_exc);
      step();
    end else begin
      if (lat == 0) begin
        exp_result = 32'h0;
        exp_exc    = op_exc;
        exp_tflag  = 1'b1;
      end else begin
        exp_result = r;
        exp_exc    = exc ? op_exc : 3'd0;
      end
      exp_tag = tag;
      @(negedge clock);
      check_eq("done_rv", result_valid, 1);
      check_eq("done_stall", pipeline_stall, 0);
      check_eq("done_result", result, exp_result);
      check_eq("done_tag", result_tag, exp_tag);
      check_eq("done_exc", exc_code, exp_exc);
      check_eq("done_busy", busy_cycles, (wcycles > SAT) ? SAT : wcycles);
      check_eq("done_md_a", md_a, a);
      check_eq("done_md_b", md_b, b);
      check_eq("done_tflag", timeout_flag, exp_tflag);
      step();
      op_valid = 1'b0;
    end
  endtask

  initial begin
    // Reset held over two edges.
    op_valid = 1'b1;
    step();
    step();
    @(negedge clock);
    check_eq("rst_start", {md_ctrl_mult, md_ctrl_div}, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_busy", busy_cycles, 0);
    check_eq("rst_md_a", md_a, 0);
    check_eq("rst_rv", result_valid, 0);
    check_eq("rst_tflag", timeout_flag, 0);
    op_valid = 1'b0;
    step();
    reset = 1'b0;
    step();

    do_op(32'd7, 32'd6, 1'b0, 5'd3, 32, 1'b0, 1'b0);
    do_op(32'd9, 32'd0, 1'b1, 5'd9, 5, 1'b1, 1'b0);
    do_op(32'h7FFF_FFFF, 32'd2, 1'b0, 5'd10, 4, 1'b1, 1'b0);
    do_op(32'd100, 32'd7, 1'b1, 5'd11, 6, 1'b0, 1'b0);
    do_op(32'd123, 32'd456, 1'b0, 5'd12, 8, 1'b1, 1'b1);

    // Flush in IDLE must block acceptance.
    op_valid = 1'b1; flush = 1'b1; operand_a = 32'hABCD;
    @(negedge clock);
    step();
    op_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    check_eq("idle_flush_no_start", {md_ctrl_mult, md_ctrl_div}, 0);
    step();

    // Asynchronous reset in the middle of WAIT.
    op_valid = 1'b1; op_is_div = 1'b0; op_tag = 5'd5; operand_a = 32'd11; operand_b = 32'd13;
    step();
    step();
    step();
    step();
    #2;
    reset = 1'b1; op_valid = 1'b0;
    #1;
    check_eq("arst_stall", pipeline_stall, 0);
    check_eq("arst_md_a", md_a, 0);
    check_eq("arst_busy", busy_cycles, 0);
    check_eq("arst_result", result, 0);
    check_eq("arst_tag", result_tag, 0);
    step();
    reset = 1'b0;
    exp_result = '0; exp_tag = '0; exp_exc = '0;
    step();
    do_op(32'd5, 32'd5, 1'b0, 5'd17, 3, 1'b0, 1'b0);

`ifdef MULTDIV_WATCHDOG_EN
    do_op(32'd50, 32'd5, 1'b1, 5'd20, 0, 1'b0, 1'b0);
    do_op(32'd3, 32'd4, 1'b0, 5'd21, 2, 1'b0, 1'b0);
`else
    do_op(32'd50, 32'd5, 1'b1, 5'd20, 70, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 25; k++) begin
      logic        dv = 1'($urandom);
      logic [31:0] ra = $urandom;
      logic [31:0] rb = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      do_op(ra, rb, dv, 5'($urandom), $urandom_range(1, 35), 1'($urandom),
            $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
